// File: rtl/counter_seq_pkg.sv
// Shared types and default sizing for the counter run controller.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/counter_sequencer.sv
// Run controller that gates an external counter's enable until it reaches a
// latched target or a step budget expires, then reports sticky status.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int SW     = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clr_first,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             timeout_err,
  output logic [SW-1:0]    steps
);

  localparam logic [SW-1:0] STEP_MAX = SW'(TIMEOUT);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] target_q;
  logic             accept;
  logic             step_inc;
  logic             set_hit;
  logic             set_tmo;
  logic             abort_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      target_q    <= '0;
      steps       <= '0;
      hit         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        target_q    <= target;
        steps       <= '0;
        hit         <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        // steps never advances past the budget, so it cannot wrap
        if (step_inc && (steps != STEP_MAX))
          steps <= steps + SW'(1);
        if (set_hit)
          hit <= 1'b1;
        if (set_tmo)
          timeout_err <= 1'b1;
        if (abort_run) begin
          hit         <= 1'b0;
          timeout_err <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    accept     = 1'b0;
    step_inc   = 1'b0;
    set_hit    = 1'b0;
    set_tmo    = 1'b0;
    abort_run  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = clr_first ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        cnt_clr    = 1'b1;
        next_state = abort ? IDLE : RUN;
      end
      RUN: begin
        // match is checked before enabling, so an already-matching count takes zero steps
        if (abort) begin
          abort_run  = 1'b1;
          next_state = IDLE;
        end else if (count == target_q) begin
          set_hit    = 1'b1;
          next_state = DONE;
        end else if (steps == STEP_MAX) begin
          set_tmo    = 1'b1;
          next_state = DONE;
        end else if (!pause) begin
          cnt_en   = 1'b1;
          step_inc = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer driving a behavioural 4-bit counter
// with enable, clear, preload and stuck-at mode.
module tb_counter_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       clr_first;
  logic [3:0] target;
  logic       pause;
  logic       abort;
  logic [3:0] count_m;
  logic       cnt_en;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic       hit;
  logic       timeout_err;
  logic [4:0] steps;

  logic       load;
  logic [3:0] load_val;
  logic       stuck;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   c;
    logic [5:0] bits;
  } trace_t;

  typedef struct {
    int   c;
    logic hit;
    logic tmo;
    logic [4:0] steps;
  } done_t;

  trace_t trace_q[$];
  done_t  done_q[$];

  counter_sequencer #(.WIDTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clr_first   (clr_first),
    .target      (target),
    .pause       (pause),
    .abort       (abort),
    .count       (count_m),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .timeout_err (timeout_err),
    .steps       (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counter; stuck mode ignores both enable and clear
  always @(posedge clk) begin
    if (load)
      count_m <= load_val;
    else if (!stuck && cnt_clr)
      count_m <= 4'd0;
    else if (!stuck && cnt_en)
      count_m <= count_m + 4'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares scheduled per-cycle traces and every done pulse
  always @(negedge clk) begin
    if (trace_q.size() > 0 && trace_q[0].c == cyc) begin
      checkOutput($sformatf("trace c%0d {en,clr,busy,done,hit,tmo}", cyc),
                  {26'd0, cnt_en, cnt_clr, busy, done, hit, timeout_err},
                  {26'd0, trace_q[0].bits});
      void'(trace_q.pop_front());
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checkOutput($sformatf("unexpected done c%0d", cyc), 32'd1, 32'd0);
      end else begin
        checkOutput("done cycle", cyc, done_q[0].c);
        checkOutput("done hit", {31'd0, hit}, {31'd0, done_q[0].hit});
        checkOutput("done timeout_err", {31'd0, timeout_err}, {31'd0, done_q[0].tmo});
        checkOutput("done steps", {27'd0, steps}, {27'd0, done_q[0].steps});
        void'(done_q.pop_front());
      end
    end
  end

  task automatic push_tr(input int c, input logic en, input logic clr, input logic bsy,
                         input logic dn, input logic h, input logic t);
    trace_t e;
    e.c    = c;
    e.bits = {en, clr, bsy, dn, h, t};
    trace_q.push_back(e);
  endtask

  task automatic push_done(input int c, input logic h, input logic t, input logic [4:0] s);
    done_t e;
    e.c     = c;
    e.hit   = h;
    e.tmo   = t;
    e.steps = s;
    done_q.push_back(e);
  endtask

  task automatic load_counter(input logic [3:0] v, input logic stk);
    @(posedge clk); #1;
    load     = 1'b1;
    load_val = v;
    stuck    = stk;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Issues a one-cycle start; c0 is the cycle in which start is sampled
  task automatic applyStimulus(input logic [3:0] tgt, input logic clr, output int c0);
    @(posedge clk); #1;
    start     = 1'b1;
    clr_first = clr;
    target    = tgt;
    c0        = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    clr_first = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (trace_q.size() == 0 && done_q.size() == 0) break;
    end
    checkOutput("scoreboard drained", trace_q.size() + done_q.size(), 32'd0);
    trace_q.delete();
    done_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; clr_first = 1'b0; target = 4'd0;
    pause = 1'b0; abort = 1'b0; load = 1'b0; load_val = 4'd0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset cnt_en", {31'd0, cnt_en}, 32'd0);
    checkOutput("reset cnt_clr", {31'd0, cnt_clr}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset hit/tmo/steps", {25'd0, hit, timeout_err, steps}, 32'd0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a run with the counter held at 3
    load_counter(4'd3, 1'b1);
    applyStimulus(4'd9, 1'b0, c0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("pre-reset busy/cnt_en", {30'd0, busy, cnt_en}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset cnt_en/cnt_clr/done", {29'd0, cnt_en, cnt_clr, done}, 32'd0);
    checkOutput("async reset hit/tmo/steps", {25'd0, hit, timeout_err, steps}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    stuck = 1'b0;
    repeat (3) @(posedge clk);

    // Clear-first run from 9 to target 5
    load_counter(4'd9, 1'b0);
    applyStimulus(4'd5, 1'b1, c0);
    push_tr(c0 + 1, 0, 1, 1, 0, 0, 0);
    for (int k = 2; k <= 6; k++) push_tr(c0 + k, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 7, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 8, 0, 0, 1, 1, 1, 0);
    push_tr(c0 + 9, 0, 0, 0, 0, 1, 0);
    push_done(c0 + 8, 1'b1, 1'b0, 5'd5);
    wait_drain();

    // Counter stuck at 3 never reaches 9: budget of 16 steps runs out
    load_counter(4'd3, 1'b1);
    applyStimulus(4'd9, 1'b0, c0);
    for (int k = 1; k <= 16; k++) push_tr(c0 + k, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 17, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 18, 0, 0, 1, 1, 0, 1);
    push_tr(c0 + 19, 0, 0, 0, 0, 0, 1);
    push_done(c0 + 18, 1'b0, 1'b1, 5'd16);
    wait_drain();
    stuck = 1'b0;

    // Pause held for two cycles delays done by two cycles
    load_counter(4'd11, 1'b0);
    applyStimulus(4'd4, 1'b1, c0);
    push_tr(c0 + 1, 0, 1, 1, 0, 0, 0);
    push_tr(c0 + 2, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 3, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 4, 0, 0, 1, 0, 0, 0);
    for (int k = 5; k <= 7; k++) push_tr(c0 + k, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 8, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 9, 0, 0, 1, 1, 1, 0);
    push_tr(c0 + 10, 0, 0, 0, 0, 1, 0);
    push_done(c0 + 9, 1'b1, 1'b0, 5'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1'b0;
    wait_drain();

    // Abort coincides with the match; a start while busy must not retarget
    load_counter(4'd0, 1'b0);
    applyStimulus(4'd2, 1'b0, c0);
    push_tr(c0 + 1, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 2, 1, 0, 1, 0, 0, 0);
    push_tr(c0 + 3, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 4, 0, 0, 0, 0, 0, 0);
    push_tr(c0 + 5, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b1; clr_first = 1'b1; target = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; clr_first = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_drain();

    // Already at target: zero steps, done two cycles after start
    load_counter(4'd7, 1'b0);
    applyStimulus(4'd7, 1'b0, c0);
    push_tr(c0 + 1, 0, 0, 1, 0, 0, 0);
    push_tr(c0 + 2, 0, 0, 1, 1, 1, 0);
    push_tr(c0 + 3, 0, 0, 0, 0, 1, 0);
    push_done(c0 + 2, 1'b1, 1'b0, 5'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
